// File: rtl/bzmusic_if.sv
// Strobe/status bundle between the buzzer-music FSM (master) and its datapath (slave).
interface bzmusic_if #(
  parameter int ADDR_W = 6
);
  logic              addr_en;
  logic              addr_rstn;
  logic              tune_pwm_en;
  logic              tune_pwm_rstn;
  logic              beat_cnt_en;
  logic              beat_cnt_rstn;
  logic              addr_finish;
  logic              beat_finish;
  logic              buzzer;
  logic [ADDR_W-1:0] note_addr;

  modport master (
    output addr_en, addr_rstn, tune_pwm_en, tune_pwm_rstn, beat_cnt_en, beat_cnt_rstn,
    input  addr_finish, beat_finish, buzzer, note_addr
  );

  modport slave (
    input  addr_en, addr_rstn, tune_pwm_en, tune_pwm_rstn, beat_cnt_en, beat_cnt_rstn,
    output addr_finish, beat_finish, buzzer, note_addr
  );
endinterface

// File: rtl/bzmusic_datapath.sv
// Buzzer-music datapath: score ROM, note address, tone divider and beat counter, slaved to FSM strobes.
// Optional BZMUSIC_LOOP_EN: score wraps to entry 0 instead of stopping at the end marker.
module bzmusic_datapath #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int SCORE_LEN   = 32,
  parameter int ADDR_W      = 6
) (
  input  logic     clk,
  input  logic     rstn,
  bzmusic_if.slave bus
);

  localparam int TICK_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int HP_MAX = CLK_HZ / (2 * 262);
  localparam int DIV_W  = ($clog2(HP_MAX + 1) > 17) ? $clog2(HP_MAX + 1) : 17;

  // Score entry = {tone[4:0], beats[2:0]}; beats==0 marks the end of the melody.
  function automatic logic [7:0] rom_rd(input logic [ADDR_W-1:0] a);
    logic [7:0] d;
    d = 8'd0;
    if (int'(a) < SCORE_LEN) begin
      case (int'(a))
        0:       d = {5'd8,  3'd1};
        1:       d = {5'd10, 3'd1};
        2:       d = {5'd12, 3'd2};
        3:       d = {5'd0,  3'd1};
        4:       d = {5'd15, 3'd4};
        default: d = 8'd0;
      endcase
    end
    return d;
  endfunction

  // Every arm is an elaboration-time constant, so this folds into a small lookup table.
  function automatic logic [DIV_W-1:0] half_period(input logic [4:0] t);
    int hp;
    hp = 0;
    case (t)
      5'd1:    hp = CLK_HZ / (2 * 262);
      5'd2:    hp = CLK_HZ / (2 * 294);
      5'd3:    hp = CLK_HZ / (2 * 330);
      5'd4:    hp = CLK_HZ / (2 * 349);
      5'd5:    hp = CLK_HZ / (2 * 392);
      5'd6:    hp = CLK_HZ / (2 * 440);
      5'd7:    hp = CLK_HZ / (2 * 494);
      5'd8:    hp = CLK_HZ / (2 * 523);
      5'd9:    hp = CLK_HZ / (2 * 587);
      5'd10:   hp = CLK_HZ / (2 * 659);
      5'd11:   hp = CLK_HZ / (2 * 698);
      5'd12:   hp = CLK_HZ / (2 * 784);
      5'd13:   hp = CLK_HZ / (2 * 880);
      5'd14:   hp = CLK_HZ / (2 * 988);
      5'd15:   hp = CLK_HZ / (2 * 1047);
      5'd16:   hp = CLK_HZ / (2 * 1175);
      5'd17:   hp = CLK_HZ / (2 * 1319);
      5'd18:   hp = CLK_HZ / (2 * 1397);
      5'd19:   hp = CLK_HZ / (2 * 1568);
      5'd20:   hp = CLK_HZ / (2 * 1760);
      5'd21:   hp = CLK_HZ / (2 * 1976);
      default: hp = 0;
    endcase
    return DIV_W'(hp);
  endfunction

  logic [ADDR_W-1:0] addr;
  logic [7:0]        note_reg;
  logic [7:0]        rom_data;
  logic              end_reached;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        beat_idx;
  logic              tick_wrap;
  logic              beat_done;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  tone_hp;
  logic              tone_valid;
  logic              buzzer_q;

  assign rom_data    = rom_rd(addr);
  assign end_reached = (addr == ADDR_W'(SCORE_LEN)) || (rom_data[2:0] == 3'd0);

  // Address / note register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr     <= '0;
      note_reg <= '0;
    end else if (!bus.addr_rstn) begin
      addr     <= '0;
      note_reg <= '0;
    end else if (bus.addr_en) begin
      if (!end_reached) begin
        note_reg <= rom_data;
        addr     <= addr + 1'b1;
      end
`ifdef BZMUSIC_LOOP_EN
      else begin
        note_reg <= rom_rd('0);
        addr     <= ADDR_W'(1);
      end
`endif
    end
  end

  // Beat counter: note lasts beats*BEAT_CYCLES enabled cycles
  assign tick_wrap = (tick_cnt == TICK_W'(BEAT_CYCLES - 1));
  assign beat_done = bus.beat_cnt_en && tick_wrap && (beat_idx == (note_reg[2:0] - 3'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_cnt <= '0;
      beat_idx <= '0;
    end else if (!bus.beat_cnt_rstn) begin
      tick_cnt <= '0;
      beat_idx <= '0;
    end else if (bus.beat_cnt_en) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        beat_idx <= beat_done ? 3'd0 : beat_idx + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  // Tone divider: buzzer toggles once every half period; rests hold it low
  assign tone_hp    = half_period(note_reg[7:3]);
  assign tone_valid = (tone_hp != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt  <= '0;
      buzzer_q <= 1'b0;
    end else if (!bus.tune_pwm_rstn) begin
      div_cnt  <= '0;
      buzzer_q <= 1'b0;
    end else if (bus.tune_pwm_en) begin
      if (!tone_valid) begin
        div_cnt  <= '0;
        buzzer_q <= 1'b0;
      end else if (div_cnt == tone_hp - 1'b1) begin
        div_cnt  <= '0;
        buzzer_q <= ~buzzer_q;
      end else begin
        div_cnt  <= div_cnt + 1'b1;
      end
    end
  end

`ifdef BZMUSIC_LOOP_EN
  assign bus.addr_finish = 1'b0;
`else
  assign bus.addr_finish = end_reached;
`endif
  assign bus.beat_finish = beat_done;
  assign bus.buzzer      = buzzer_q;
  assign bus.note_addr   = addr;

endmodule

// File: tb/tb_bzmusic_datapath.sv
// Directed bench for bzmusic_datapath, driving the strobes the way the music FSM would.
// Run with CLK_HZ=100_000 so tone toggles fall inside 100-cycle beats.
module tb_bzmusic_datapath;
  localparam int CLK_HZ      = 100_000;
  localparam int BEAT_CYCLES = 100;
  localparam int SCORE_LEN   = 32;
  localparam int ADDR_W      = 6;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  bzmusic_if #(.ADDR_W(ADDR_W)) bif ();

  bzmusic_datapath #(
    .CLK_HZ     (CLK_HZ),
    .BEAT_CYCLES(BEAT_CYCLES),
    .SCORE_LEN  (SCORE_LEN),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One transition cycle: load next note, restart tone phase and beat count.
  task automatic load_next(input string tag, input int exp_addr);
    bif.addr_en       = 1'b1;
    bif.tune_pwm_rstn = 1'b0;
    bif.beat_cnt_rstn = 1'b0;
    bif.tune_pwm_en   = 1'b0;
    bif.beat_cnt_en   = 1'b0;
    @(negedge clk);
    bif.addr_en       = 1'b0;
    bif.tune_pwm_rstn = 1'b1;
    bif.beat_cnt_rstn = 1'b1;
    check({tag, " note_addr"}, 32'(bif.note_addr), exp_addr);
  endtask

  task automatic run_note(input string tag, input int beats, input int exp_first, input int exp_toggles);
    int   c;
    int   first;
    int   toggles;
    logic prev;
    bit   found;
    c = 0; first = 0; toggles = 0; prev = 1'b0; found = 1'b0;
    bif.tune_pwm_en = 1'b1;
    bif.beat_cnt_en = 1'b1;
    check({tag, " buzzer start"}, 32'(bif.buzzer), 0);
    while (!found && c < beats * BEAT_CYCLES + 50) begin
      if (c > 0) @(negedge clk);
      c++;
      if (bif.buzzer !== prev) begin
        toggles++;
        if (first == 0) first = c;
        prev = bif.buzzer;
      end
      if (bif.beat_finish === 1'b1) found = 1'b1;
    end
    check({tag, " beat_finish cycle"}, found ? c : 0, beats * BEAT_CYCLES);
    check({tag, " first toggle"}, first, exp_first);
    check({tag, " toggle count"}, toggles, exp_toggles);
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rstn              = 1'b0;
    bif.addr_en       = 1'b0;
    bif.addr_rstn     = 1'b1;
    bif.tune_pwm_en   = 1'b0;
    bif.tune_pwm_rstn = 1'b1;
    bif.beat_cnt_en   = 1'b0;
    bif.beat_cnt_rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("reset buzzer", 32'(bif.buzzer), 0);
    check("reset note_addr", 32'(bif.note_addr), 0);
    check("reset beat_finish", 32'(bif.beat_finish), 0);
    check("reset addr_finish", 32'(bif.addr_finish), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Half periods at 100 kHz: C5 95, E5 75, G5 63, C6 47; first toggle seen one sample later.
    load_next("n0", 1); run_note("n0", 1, 96, 1);
    load_next("n1", 2); run_note("n1", 1, 76, 1);
    load_next("n2", 3); run_note("n2", 2, 64, 3);
    load_next("n3", 4); run_note("n3", 1, 0, 0);
    load_next("n4", 5); run_note("n4", 4, 48, 8);

`ifdef BZMUSIC_LOOP_EN
    check("wrap addr_finish", 32'(bif.addr_finish), 0);
    load_next("wrap", 1);
    check("wrap addr_finish after", 32'(bif.addr_finish), 0);
    run_note("n0 again", 1, 96, 1);
`else
    check("end addr_finish", 32'(bif.addr_finish), 1);
    load_next("end", 5);
    check("end buzzer", 32'(bif.buzzer), 0);
    repeat (3) @(negedge clk);
    check("end hold note_addr", 32'(bif.note_addr), 5);
    check("end hold addr_finish", 32'(bif.addr_finish), 1);
`endif

    bif.addr_rstn = 1'b0;
    @(negedge clk);
    bif.addr_rstn = 1'b1;
    check("addr_rstn note_addr", 32'(bif.note_addr), 0);
    check("addr_rstn addr_finish", 32'(bif.addr_finish), 0);

    // Async reset in the middle of a sounding tone
    load_next("rl", 1);
    bif.tune_pwm_en = 1'b1;
    bif.beat_cnt_en = 1'b1;
    repeat (95) @(negedge clk);
    check("pre-reset buzzer", 32'(bif.buzzer), 1);
    #2 rstn = 1'b0;
    #1;
    check("async buzzer", 32'(bif.buzzer), 0);
    check("async note_addr", 32'(bif.note_addr), 0);
    check("async beat_finish", 32'(bif.beat_finish), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // beat_finish is qualified by beat_cnt_en combinationally
    load_next("gate", 1);
    bif.beat_cnt_en = 1'b1;
    repeat (99) @(negedge clk);
    check("gate finish en=1", 32'(bif.beat_finish), 1);
    bif.beat_cnt_en = 1'b0;
    #1;
    check("gate finish en=0", 32'(bif.beat_finish), 0);
    @(negedge clk);
    check("gate held finish en=0", 32'(bif.beat_finish), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
